pwm_duty_responder: RTL

//  Responder end of the CPU->PWM duty-cycle req/ack link. The MMIO block drives tx_req plus a 12-bit duty word.

---
 rtl/pwm_duty_responder_if.sv | 35 +++
 rtl/pwm_duty_responder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_responder_if.sv
// -----------------------------------------------------------------------------
// pwm_duty_responder_if
//   Duty-word req/ack link between the MMIO initiator (mmap_mem) and the PWM
//   responder.
//
//   Signals
//     tx_req   initiator -> responder  request; tx_duty valid while high
//     tx_duty  initiator -> responder  requested duty (high cycles per period)
//     tx_ack   responder -> initiator  registered acknowledge (4-phase)
//
//   Modports
//     master   initiator side (drives tx_req/tx_duty, observes tx_ack)
//     slave    responder side (observes tx_req/tx_duty, drives tx_ack)
// -----------------------------------------------------------------------------
interface pwm_duty_responder_if #(
  parameter int unsigned DUTY_W = 12
);

  logic              tx_req;
  logic [DUTY_W-1:0] tx_duty;
  logic              tx_ack;

  modport master (
    output tx_req,
    output tx_duty,
    input  tx_ack
  );

  modport slave (
    input  tx_req,
    input  tx_duty,
    output tx_ack
  );

endinterface

// File: rtl/pwm_duty_responder.sv
// -----------------------------------------------------------------------------
// pwm_duty_responder
//   Responder end of the CPU->PWM duty-cycle req/ack link. Captures the duty
//   word offered on the link, completes a 4-phase handshake on tx_ack and
//   drives pwm_out from it. A freshly captured duty word is held in a shadow
//   register and only becomes active at a PWM period boundary, so pwm_out
//   never shows a truncated or stretched pulse.
//
//   Parameters
//     DUTY_W     width of duty word and PWM counter; period = 2**DUTY_W cycles
//     ACK_DELAY  extra cycles between capture and raising tx_ack (0..15)
//
//   Ports
//     clk           in   system clock, all logic on posedge
//     reset         in   asynchronous active-high reset (sync release expected)
//     bus           if   slave side of the req/ack link (tx_req, tx_duty, tx_ack)
//     pwm_out       out  registered PWM output
//     period_start  out  1-cycle pulse while the PWM counter is 0
//     update_pend   out  a captured duty word waits for the next boundary
//
//   Build option
//     PWM_REQ_SYNC_EN  when defined, tx_req passes through a 2-flop
//                      synchronizer before the handshake FSM (capture and ack
//                      latency grow by 2 clk; tx_duty must then stay stable
//                      from tx_req rise until tx_ack rises). When undefined
//                      the initiator is assumed to share this clock.
// -----------------------------------------------------------------------------
module pwm_duty_responder #(
  parameter int unsigned DUTY_W    = 12,
  parameter int unsigned ACK_DELAY = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  pwm_duty_responder_if.slave         bus,
  output logic                        pwm_out,
  output logic                        period_start,
  output logic                        update_pend
);

  // ---------------------------------------------------------------------------
  // Request as seen by the FSM
  // ---------------------------------------------------------------------------
  logic req_s;

`ifdef PWM_REQ_SYNC_EN
  logic [1:0] req_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_sync <= '0;
    end else begin
      req_sync <= {req_sync[0], bus.tx_req};
    end
  end

  assign req_s = req_sync[1];
`else
  assign req_s = bus.tx_req;
`endif

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    ACKED = 2'd2
  } state_t;

  state_t     state;
  state_t     state_d;
  logic [3:0] dly;
  logic [3:0] dly_d;
  logic       ack_q;
  logic       ack_d;
  logic       capture;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      dly   <= '0;
      ack_q <= 1'b0;
    end else begin
      state <= state_d;
      dly   <= dly_d;
      ack_q <= ack_d;
    end
  end

  // Next-state logic. DELAY leaves unconditionally once dly reaches 1, so a
  // request dropped early still produces a single-cycle ack and returns to
  // IDLE rather than hanging.
  always_comb begin
    state_d = state;
    dly_d   = dly;
    case (state)
      IDLE: begin
        if (req_s) begin
          dly_d   = 4'(ACK_DELAY);
          state_d = (ACK_DELAY == 0) ? ACKED : DELAY;
        end
      end
      DELAY: begin
        dly_d = dly - 4'd1;
        if (dly <= 4'd1) begin
          state_d = ACKED;
        end
      end
      ACKED: begin
        if (!req_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic. tx_ack is high exactly while the FSM sits in ACKED; it is
  // computed from the next state and registered so the pin stays glitch-free.
  always_comb begin
    ack_d   = (state_d == ACKED);
    capture = (state == IDLE) && req_s;
  end

  assign bus.tx_ack = ack_q;

  // ---------------------------------------------------------------------------
  // PWM datapath
  // ---------------------------------------------------------------------------
  logic [DUTY_W-1:0] cnt;
  logic [DUTY_W-1:0] active_duty;
  logic [DUTY_W-1:0] shadow_duty;
  logic              boundary;

  // Last counter value of the period; the next edge starts a new period.
  assign boundary = (cnt == '1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      active_duty  <= '0;
      shadow_duty  <= '0;
      update_pend  <= 1'b0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      cnt          <= cnt + DUTY_W'(1);
      pwm_out      <= (cnt < active_duty);
      period_start <= boundary;

      // Non-blocking reads mean a capture on the boundary edge still loads
      // the previous shadow; capture wins the pending flag so the new word
      // is applied at the following boundary.
      if (boundary && update_pend) begin
        active_duty <= shadow_duty;
      end

      if (capture) begin
        shadow_duty <= bus.tx_duty;
        update_pend <= 1'b1;
      end else if (boundary) begin
        update_pend <= 1'b0;
      end
    end
  end

endmodule
